phy_rx_lane: RTL and testbench
==============================

PHY_RX_LANE -- requirements
Module: phy_rx_lane

Interface
REQ-001 SHALL have parameter COM, default 8'hBC, meaning the idle/alignment character.
REQ-002 SHALL have parameter BC_TO_ACTIVE, default 4, meaning the number of consecutive aligned COM bytes needed to enter ACTIVE (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, one serial bit per rising edge; the block has one clock only.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_rx_serial, input, 1 bit: the serial line, MSB of each byte first (the counterpart of out_tx_serial_0/1).
REQ-006 SHALL have port data_out, output, 32 bits: the assembled word; the first received data byte is placed in [31:24].
REQ-007 SHALL have port valid_out, output, 1 bit: one-cycle strobe marking data_out as new.
REQ-008 SHALL have port active, output, 1 bit: high while the lane is in ACTIVE.
REQ-009 SHALL have port word_err, output, 1 bit: one-cycle pulse when a partial word is discarded.

Function
REQ-010 SHALL shift in_rx_serial into an 8-bit register sr on every rising clk edge: sr <= {sr[6:0], in_rx_serial}; "new byte" means {sr[6:0], in_rx_serial} on that edge.
REQ-011 SHALL implement the states SEARCH, ALIGNED and ACTIVE; every output is registered.
REQ-012 In SEARCH, SHALL compare the new byte with COM on every edge; on a match go to ALIGNED with bc_cnt=1 and bit_cnt=0.
REQ-013 Outside SEARCH, SHALL have a 3-bit bit_cnt that increments every edge and wraps 7->0; the edge on which bit_cnt==7 is the byte-complete edge.
REQ-014 In ALIGNED, on a byte-complete edge:
  - new byte == COM: increment bc_cnt; when bc_cnt reaches BC_TO_ACTIVE, go to ACTIVE and set active=1 on that edge.
  - otherwise: go to SEARCH and set bc_cnt=0.
REQ-015 With BC_TO_ACTIVE=1, SHALL go from SEARCH directly to ACTIVE on the first COM match.
REQ-016 In ACTIVE, on a byte-complete edge, a non-COM byte SHALL be stored in the word slot byte_idx (0 maps to [31:24]) and byte_idx SHALL increment.
REQ-017 When the byte stored is for byte_idx==3, SHALL load data_out with the complete word (including that byte), pulse valid_out high for exactly one cycle on that edge, and reset byte_idx to 0.
REQ-018 In ACTIVE, a COM byte SHALL be treated as idle; if byte_idx!=0, the partial word SHALL be discarded, word_err SHALL pulse for one cycle, and byte_idx SHALL reset to 0.
REQ-019 data_out SHALL hold its last value between valid_out strobes and SHALL never change without valid_out.
REQ-020 ACTIVE SHALL be sticky until reset; there is no in-band loss-of-sync detection.
REQ-021 Latency: valid_out SHALL assert on the same edge that samples the last bit of the 4th data byte.
REQ-022 valid_out and word_err SHALL never assert in the same cycle.
REQ-023 word_err SHALL never assert outside ACTIVE.

Reset
REQ-024 While reset is high (asynchronous), SHALL hold: state=SEARCH, sr=0, bit_cnt=0, bc_cnt=0, byte_idx=0, data_out=32'h0, valid_out=0, active=0, word_err=0.
REQ-025 Reset asserted mid-word or mid-alignment SHALL abort immediately with no valid_out or word_err pulse; after release, alignment SHALL restart from SEARCH.

Verification
REQ-026 Reset, then 4x 8'hBC from bit 1 -> active rises on the edge sampling bit 32; valid_out stays 0.
REQ-027 Continue from REQ-026 with bytes 12,34,56,78 -> data_out=32'h12345678 and valid_out high for exactly 1 cycle on the bit-64 edge.
REQ-028 3 junk bits 3'b101, then 4x BC, then 0xDEADBEEF -> alignment found at bit offset 3 and data_out=32'hDEADBEEF.
REQ-029 Enter ACTIVE, then AA, BB, BC, then 01,02,03,04 -> word_err 1-cycle pulse at the end of the BC byte, followed by data_out=32'h01020304 with valid_out; 32'hAABB.... never appears.
REQ-030 3x BC then 8'h00 -> return to SEARCH with active=0; then 4x BC -> active=1.
REQ-031 Enter ACTIVE, send 2 data bytes, assert reset for 1 cycle mid-byte -> all outputs go to 0 immediately; after release, active=1 only after 4 fresh BC bytes.

Source files
------------

// File: rtl/phy_rx_lane.sv
// Purpose : serial receive lane. Finds byte alignment on a repeated COM
//           character and assembles the following data bytes into 32-bit words.
// Latency : valid_out rises on the edge that samples the last bit of the 4th data byte.
// Backpr. : none. The serial line cannot be stalled, and every output is a registered strobe/level.
//
// Ports:
//   clk          single clock, one serial bit sampled per rising edge
//   reset        asynchronous, active-high
//   in_rx_serial serial data, MSB of each byte first
//   data_out     last completed word; the first byte received sits in [31:24]
//   valid_out    one-cycle strobe, data_out has just been updated
//   active       high once the lane has locked (sticky until reset)
//   word_err     one-cycle pulse when a COM interrupts a partial word
module phy_rx_lane #(
    parameter logic [7:0] COM          = 8'hBC,
    parameter int         BC_TO_ACTIVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_rx_serial,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active,
    output logic        word_err
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] LP_BC_TGT = 4'(BC_TO_ACTIVE);

    state_t      r_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_bc_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word;        // first three bytes of the word being built
    logic [31:0] r_data_out;
    logic        r_valid;
    logic        r_active;
    logic        r_word_err;

    state_t      w_state;
    logic [2:0]  w_bit_cnt;
    logic [3:0]  w_bc_cnt;
    logic [1:0]  w_byte_idx;
    logic [23:0] w_word;
    logic [31:0] w_data_out;
    logic        w_valid;
    logic        w_active;
    logic        w_word_err;

    logic [7:0]  w_new_byte;
    logic        w_is_com;
    logic        w_byte_done;

    // The byte as it stands once this edge's bit is shifted in.
    assign w_new_byte  = {r_sr[6:0], in_rx_serial};
    assign w_is_com    = (w_new_byte == COM);
    assign w_byte_done = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_SEARCH;
            r_sr       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_bc_cnt   <= 4'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'h0;
            r_data_out <= 32'h0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_word_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sr       <= w_new_byte;
            r_bit_cnt  <= w_bit_cnt;
            r_bc_cnt   <= w_bc_cnt;
            r_byte_idx <= w_byte_idx;
            r_word     <= w_word;
            r_data_out <= w_data_out;
            r_valid    <= w_valid;
            r_active   <= w_active;
            r_word_err <= w_word_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_bit_cnt  = r_bit_cnt + 3'd1;
        w_bc_cnt   = r_bc_cnt;
        w_byte_idx = r_byte_idx;
        w_word     = r_word;
        w_data_out = r_data_out;
        w_valid    = 1'b0;
        w_active   = r_active;
        w_word_err = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                // Sliding-window hunt: every edge is a candidate byte boundary.
                w_bit_cnt = 3'd0;
                if (w_is_com) begin
                    w_bc_cnt = 4'd1;
                    if (LP_BC_TGT == 4'd1) begin
                        w_state  = ST_ACTIVE;
                        w_active = 1'b1;
                    end else begin
                        w_state = ST_ALIGNED;
                    end
                end
            end

            ST_ALIGNED: begin
                if (w_byte_done) begin
                    if (w_is_com) begin
                        w_bc_cnt = r_bc_cnt + 4'd1;
                        if ((r_bc_cnt + 4'd1) == LP_BC_TGT) begin
                            w_state  = ST_ACTIVE;
                            w_active = 1'b1;
                        end
                    end else begin
                        // Alignment was a false hit; start hunting again.
                        w_state  = ST_SEARCH;
                        w_bc_cnt = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (w_byte_done) begin
                    if (!w_is_com) begin
                        case (r_byte_idx)
                            2'd0:    w_word[23:16] = w_new_byte;
                            2'd1:    w_word[15:8]  = w_new_byte;
                            2'd2:    w_word[7:0]   = w_new_byte;
                            default: begin
                                w_data_out = {r_word, w_new_byte};
                                w_valid    = 1'b1;
                            end
                        endcase
                        // Two-bit index wraps 3 -> 0 on word completion.
                        w_byte_idx = r_byte_idx + 2'd1;
                    end else if (r_byte_idx != 2'd0) begin
                        // Idle character inside a word: drop the partial word.
                        w_word_err = 1'b1;
                        w_byte_idx = 2'd0;
                    end
                end
            end

            default: begin
                w_state = ST_SEARCH;
            end
        endcase
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign active    = r_active;
    assign word_err  = r_word_err;

endmodule

// File: tb/tb_phy_rx_lane.sv
// Purpose : self-checking bench for phy_rx_lane. A byte-level reference model
//           predicts words/errors into a queue that a separate monitor drains.
// Latency : n/a. Backpressure: n/a (serial input is free-running).
module tb_phy_rx_lane;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         BCT = 4;

    logic        clk;
    logic        reset;
    logic        in_rx_serial;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;
    logic        word_err;

    phy_rx_lane #(.COM(COM), .BC_TO_ACTIVE(BCT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_rx_serial (in_rx_serial),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .active       (active),
        .word_err     (word_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-level view of the lane) ----------
    typedef struct {
        int          e;      // edge number (since reset release) of the event
        bit          err;    // 1 = word_err, 0 = valid_out
        logic [31:0] d;
    } evt_t;

    evt_t       exp_q[$];
    int         edge_n = 0;
    logic [7:0] m_win;
    bit         m_aligned;
    bit         m_active;
    int         m_run;
    int         m_bits;
    logic [7:0] m_part[$];

    task automatic model_clear();
        m_win     = 8'h00;
        m_aligned = 1'b0;
        m_active  = 1'b0;
        m_run     = 0;
        m_bits    = 0;
        m_part.delete();
        exp_q.delete();
    endtask

    task automatic model_bit(input bit b);
        evt_t ev;
        int   e;
        e     = edge_n + 1;
        m_win = {m_win[6:0], b};
        if (!m_aligned) begin
            if (m_win == COM) begin
                m_aligned = 1'b1;
                m_bits    = 0;
                m_run     = 1;
                if (m_run >= BCT) m_active = 1'b1;
            end
        end else begin
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (!m_active) begin
                    if (m_win == COM) begin
                        m_run++;
                        if (m_run >= BCT) m_active = 1'b1;
                    end else begin
                        m_aligned = 1'b0;
                        m_run     = 0;
                    end
                end else if (m_win != COM) begin
                    m_part.push_back(m_win);
                    if (m_part.size() == 4) begin
                        ev.e = e; ev.err = 1'b0;
                        ev.d = {m_part[0], m_part[1], m_part[2], m_part[3]};
                        exp_q.push_back(ev);
                        m_part.delete();
                    end
                end else if (m_part.size() != 0) begin
                    ev.e = e; ev.err = 1'b1; ev.d = 32'h0;
                    exp_q.push_back(ev);
                    m_part.delete();
                end
            end
        end
    endtask

    // ---------------- monitor --------------------------------------------
    logic [31:0] prev_data = 32'h0;
    bit          rise_seen = 1'b0;
    int          rise_edge = 0;
    evt_t        mev;

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            edge_n    = 0;
            prev_data = 32'h0;
            rise_seen = 1'b0;
        end else begin
            edge_n++;
            check("active_vs_model", {31'h0, active}, {31'h0, m_active});
            if (active && !rise_seen) begin
                rise_seen = 1'b1;
                rise_edge = edge_n;
            end
            if (valid_out && word_err)
                check("valid_and_err_together", 32'd1, 32'd0);
            if (valid_out || word_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_valid", {31'h0, valid_out}, 32'd0);
                end else begin
                    mev = exp_q.pop_front();
                    check("evt_edge", edge_n, mev.e);
                    check("evt_kind_err", {31'h0, word_err}, {31'h0, mev.err});
                    if (!mev.err) check("evt_data", data_out, mev.d);
                end
            end else begin
                check("data_hold", data_out, prev_data);
            end
            prev_data = data_out;
        end
    end

    // ---------------- stimulus ---------------------------------------------
    // Called at a negedge; sets the bit for the next rising edge, returns at the next negedge.
    task automatic send_bit(input bit b);
        in_rx_serial = b;
        model_bit(b);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_valid",    {31'h0, valid_out}, 32'd0);
        check("rst_active",   {31'h0, active}, 32'd0);
        check("rst_word_err", {31'h0, word_err}, 32'd0);
        model_clear();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] rb;
    int         nj;

    initial begin
        reset        = 1'b1;
        in_rx_serial = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);

        // Lock after four COMs from bit 1, then one word.
        do_reset(2);
        repeat (4) send_byte(COM);
        check("lock_edge_32", rise_edge, 32'd32);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("word_12345678", data_out, 32'h12345678);
        check("queue_drained_a", exp_q.size(), 32'd0);

        // Alignment at bit offset 3.
        do_reset(1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(COM);
        check("lock_edge_35", rise_edge, 32'd35);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check("word_deadbeef", data_out, 32'hDEADBEEF);

        // Partial word discarded by an idle character.
        do_reset(1);
        repeat (4) send_byte(COM);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(COM);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("word_01020304", data_out, 32'h01020304);

        // Broken alignment returns to search, then relocks.
        do_reset(1);
        repeat (3) send_byte(COM);
        send_byte(8'h00);
        check("unlock_after_00", {31'h0, active}, 32'd0);
        repeat (4) send_byte(COM);
        check("relock_after_00", {31'h0, active}, 32'd1);

        // Reset in the middle of a word.
        do_reset(1);
        repeat (4) send_byte(COM);
        send_byte(8'h11); send_byte(8'h22);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        do_reset(1);
        repeat (3) send_byte(COM);
        check("no_lock_3_fresh", {31'h0, active}, 32'd0);
        send_byte(COM);
        check("lock_4_fresh", {31'h0, active}, 32'd1);

        // Randomised traffic.
        for (int t = 0; t < 8; t++) begin
            do_reset(1 + $urandom_range(0, 2));
            nj = $urandom_range(0, 15);
            for (int j = 0; j < nj; j++) send_bit(1'($urandom_range(0, 1)));
            if (t % 2 == 1) begin
                send_byte(COM); send_byte(COM);
                rb = 8'($urandom);
                if (rb == COM) rb = 8'h00;
                send_byte(rb);
            end
            repeat (BCT + $urandom_range(0, 2)) send_byte(COM);
            for (int j = 0; j < 24; j++) begin
                if ($urandom_range(0, 5) == 0) rb = COM;
                else                           rb = 8'($urandom);
                send_byte(rb);
            end
            check("rand_queue_drained", exp_q.size(), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
